// File: rtl/ngs_boot_core_mtimer.sv
// Multi-channel interval timer on an Avalon-MM slave port, one combined irq.
// Ports: clk, reset_n, address/chipselect/write_n/writedata, readdata, irq.
//
// Per channel, address[1:0] selects the register:
//   0 STATUS  : bit0 TO, bit1 RUN; any write clears TO
//   1 CONTROL : bit0 ITO, bit1 CONT, bits[15:8] PRESC;
//               bit2 START, bit3 STOP are strobes and read back 0
//   2 PERIOD  : reload value; a write forces a reload and stops the channel
//   3 SNAP    : any write captures the live counter; read returns the copy
// address[ADDR_W-1:2] selects the channel. Channels at or above NUM_CH read 0
// and ignore writes.
module ngs_boot_core_mtimer #(
    parameter int NUM_CH         = 2,
    parameter int CNT_W          = 32,
    parameter int DEFAULT_PERIOD = 24999,
    parameter int ADDR_W         = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              irq
);

    localparam int CH_W = ADDR_W - 2;

    logic [CH_W-1:0]   ch_sel;
    logic [1:0]        reg_sel;
    logic              wr_en;
    logic [31:0]       rd_vec [NUM_CH];
    logic [31:0]       rd_data;
    logic [NUM_CH-1:0] irq_vec;

    assign ch_sel  = address[ADDR_W-1:2];
    assign reg_sel = address[1:0];
    assign wr_en   = chipselect & ~write_n;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic             hit;
        logic             wr_stat;
        logic             wr_ctrl;
        logic             wr_per;
        logic             wr_snap;
        logic             start;
        logic             stop;
        logic             tick;
        logic             cnt_zero;
        logic             to_q;
        logic             run_q;
        logic             ito_q;
        logic             cont_q;
        logic [7:0]       presc_q;
        logic [7:0]       pcnt_q;
        logic [CNT_W-1:0] period_q;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] snap_q;
        logic             reload_q;

        assign hit      = wr_en && (ch_sel == CH_W'(i));
        assign wr_stat  = hit && (reg_sel == 2'd0);
        assign wr_ctrl  = hit && (reg_sel == 2'd1);
        assign wr_per   = hit && (reg_sel == 2'd2);
        assign wr_snap  = hit && (reg_sel == 2'd3);
        assign start    = wr_ctrl && writedata[2];
        assign stop     = wr_ctrl && writedata[3];
        assign tick     = run_q && (pcnt_q == 8'd0);
        assign cnt_zero = (cnt_q == '0);

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                to_q     <= 1'b0;
                run_q    <= 1'b0;
                ito_q    <= 1'b0;
                cont_q   <= 1'b0;
                presc_q  <= 8'd0;
                pcnt_q   <= 8'd0;
                period_q <= CNT_W'(DEFAULT_PERIOD);
                cnt_q    <= CNT_W'(DEFAULT_PERIOD);
                snap_q   <= '0;
                reload_q <= 1'b0;
            end else begin
                // A PERIOD write reloads the channel one cycle later, so the
                // reload sees the freshly written period.
                reload_q <= wr_per;

                if (wr_per) begin
                    period_q <= writedata[CNT_W-1:0];
                end

                if (wr_ctrl) begin
                    ito_q   <= writedata[0];
                    cont_q  <= writedata[1];
                    presc_q <= writedata[15:8];
                end

                // Capture uses the current value, i.e. before any decrement.
                if (wr_snap) begin
                    snap_q <= cnt_q;
                end

                // The forced reload suppresses a tick landing in that cycle.
                if (reload_q) begin
                    cnt_q <= period_q;
                end else if (tick) begin
                    cnt_q <= cnt_zero ? period_q : cnt_q - CNT_W'(1);
                end

                // START takes the PRESC being written alongside it.
                if (start) begin
                    pcnt_q <= writedata[15:8];
                end else if (reload_q) begin
                    pcnt_q <= presc_q;
                end else if (run_q) begin
                    pcnt_q <= (pcnt_q == 8'd0) ? presc_q : pcnt_q - 8'd1;
                end

                if (start) begin
                    run_q <= 1'b1;
                end else if (stop || reload_q) begin
                    run_q <= 1'b0;
                end else if (tick && cnt_zero && !cont_q) begin
                    run_q <= 1'b0;
                end

                // Software clear beats a coincident timeout.
                if (wr_stat) begin
                    to_q <= 1'b0;
                end else if (tick && cnt_zero && !reload_q) begin
                    to_q <= 1'b1;
                end
            end
        end

        always_comb begin
            rd_vec[i] = '0;
            unique case (reg_sel)
                2'd0: rd_vec[i] = {30'd0, run_q, to_q};
                2'd1: rd_vec[i] = {16'd0, presc_q, 6'd0, cont_q, ito_q};
                2'd2: rd_vec[i] = 32'(period_q);
                2'd3: rd_vec[i] = 32'(snap_q);
                default: rd_vec[i] = '0;
            endcase
        end

        assign irq_vec[i] = to_q & ito_q;
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_sel == CH_W'(i)) begin
                rd_data = rd_vec[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            readdata <= rd_data;
        end
    end

    assign irq = |irq_vec;

endmodule
